// File: rtl/rca_pipe_pkg.sv
// Shared constants, chunk sizing helper and the default-sized stage record
// for the pipelined ripple-carry adder/subtractor (rca_pipe_addsub).
// Optional feature macro used by the top: ADDSUB_SAT_EN (saturating result).

package rca_pipe_pkg;

    // Default geometry of the datapath adder.
    localparam int DEF_WIDTH  = 16;
    localparam int DEF_STAGES = 4;

    // Bits handled by one pipeline stage. A zero stage count yields zero so
    // that the top can report the bad configuration instead of dividing by 0.
    function automatic int chunk_width(input int width, input int stages);
        if (stages > 0) begin
            return width / stages;
        end else begin
            return 0;
        end
    endfunction

    localparam int DEF_CW = chunk_width(DEF_WIDTH, DEF_STAGES);

    // One stage of in-flight state for the default geometry:
    //   valid  - beat present in this stage
    //   carry  - carry out of the chunk this stage just finished
    //   ovf    - carry-into-MSB xor carry-out of that chunk (meaningful at the last stage)
    //   x_rem  - operand A travelling with the beat (upper chunks still unprocessed)
    //   y_rem  - operand B already conditioned for subtraction (~y when sub)
    //   s_done - result bits; chunks below and at this stage are final
    typedef struct packed {
        logic                 valid;
        logic                 carry;
        logic                 ovf;
        logic [DEF_WIDTH-1:0] x_rem;
        logic [DEF_WIDTH-1:0] y_rem;
        logic [DEF_WIDTH-1:0] s_done;
    } stage_t;

endpackage

// File: rtl/rca_pipe_addsub_chunk.sv
// Combinational ripple of CW full adders. Besides sum and carry-out it
// exposes the carry into the chunk MSB, so the stage that owns the operand
// MSB can derive signed overflow as (carry into MSB) ^ (carry out of MSB).

module rca_chunk
    import rca_pipe_pkg::*;
#(
    parameter int CW = DEF_CW
) (
    input  logic [CW-1:0] a,
    input  logic [CW-1:0] b,
    input  logic          ci,
    output logic [CW-1:0] s,
    output logic          co,
    output logic          c_msb_in
);

    logic [CW:0] c_s;

    // Ripple the carry bit by bit from the chunk LSB upwards.
    always_comb begin
        c_s    = {(CW+1){1'b0}};
        s      = {CW{1'b0}};
        c_s[0] = ci;
        for (int i = 0; i < CW; i++) begin
            s[i]     = a[i] ^ b[i] ^ c_s[i];
            c_s[i+1] = (a[i] & b[i]) | (c_s[i] & (a[i] ^ b[i]));
        end
    end

    assign co       = c_s[CW];
    assign c_msb_in = c_s[CW-1];

endmodule

// File: rtl/rca_pipe_addsub.sv
// Pipelined ripple-carry adder/subtractor with valid/ready streaming.
// WIDTH-bit operands are cut into STAGES chunks of CW bits; stage k ripples
// chunk k using the carry registered by stage k-1. Operands travel with the
// beat so upper chunks are available when their stage is reached, and
// finished result chunks travel with it as well, so the last stage register
// holds the complete, aligned result and drives the outputs directly.
// A single global stall (output valid but not accepted) freezes every stage.
// Optional feature macro: ADDSUB_SAT_EN - when defined, the result saturates
// to the most positive/negative value on signed overflow (ovf and cout
// still report the raw event); when undefined the result wraps.

module rca_pipe_addsub
    import rca_pipe_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = chunk_width(WIDTH, STAGES);

    // Reject geometries that cannot be split into equal chunks.
    generate
        if (STAGES < 1) begin : g_bad_stages
            $error("rca_pipe_addsub: STAGES must be at least 1");
        end else if ((WIDTH % STAGES) != 0) begin : g_bad_width
            $error("rca_pipe_addsub: WIDTH must be a multiple of STAGES");
        end
    endgenerate

`ifdef ADDSUB_SAT_EN
    localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};
`endif

    // Stage record sized from this instance's geometry (same fields as
    // rca_pipe_pkg::stage_t, which is fixed to the default geometry).
    typedef struct packed {
        logic             valid;
        logic             carry;
        logic             ovf;
        logic [WIDTH-1:0] x_rem;
        logic [WIDTH-1:0] y_rem;
        logic [WIDTH-1:0] s_done;
    } pipe_stage_t;

    pipe_stage_t   stage_in_s  [STAGES];
    pipe_stage_t   stage_nxt_s [STAGES];
    pipe_stage_t   pipe_r      [STAGES];

    logic [CW-1:0] chunk_a_s   [STAGES];
    logic [CW-1:0] chunk_b_s   [STAGES];
    logic [CW-1:0] chunk_s_s   [STAGES];
    logic          chunk_ci_s  [STAGES];
    logic          chunk_co_s  [STAGES];
    logic          chunk_cm_s  [STAGES];

    logic          stall_s;

    // Whole pipe freezes only when a finished beat is waiting downstream.
    assign stall_s  = pipe_r[STAGES-1].valid & ~out_ready;
    assign in_ready = ~stall_s;

    // Stage inputs: stage 0 takes the port beat (B inverted and carry-in
    // flipped for subtraction), later stages take the previous register.
    always_comb begin
        stage_in_s[0].valid  = in_valid;
        stage_in_s[0].carry  = cin ^ sub;
        stage_in_s[0].ovf    = 1'b0;
        stage_in_s[0].x_rem  = x;
        stage_in_s[0].y_rem  = sub ? ~y : y;
        stage_in_s[0].s_done = {WIDTH{1'b0}};
        for (int k = 1; k < STAGES; k++) begin
            stage_in_s[k] = pipe_r[k-1];
        end
    end

    // One ripple chunk per stage, each fed by its own slice of the beat.
    generate
        for (genvar k = 0; k < STAGES; k++) begin : g_stage
            assign chunk_a_s[k]  = stage_in_s[k].x_rem[k*CW +: CW];
            assign chunk_b_s[k]  = stage_in_s[k].y_rem[k*CW +: CW];
            assign chunk_ci_s[k] = stage_in_s[k].carry;

            rca_chunk #(
                .CW       (CW)
            ) u_chunk (
                .a        (chunk_a_s[k]),
                .b        (chunk_b_s[k]),
                .ci       (chunk_ci_s[k]),
                .s        (chunk_s_s[k]),
                .co       (chunk_co_s[k]),
                .c_msb_in (chunk_cm_s[k])
            );
        end
    endgenerate

    // Next-state of each stage: merge the freshly computed chunk into the
    // travelling result and pass on its carry; the last stage also settles
    // overflow and, when enabled, the saturated result.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            stage_nxt_s[k]                    = stage_in_s[k];
            stage_nxt_s[k].s_done[k*CW +: CW] = chunk_s_s[k];
            stage_nxt_s[k].carry              = chunk_co_s[k];
            stage_nxt_s[k].ovf                = chunk_co_s[k] ^ chunk_cm_s[k];
        end
`ifdef ADDSUB_SAT_EN
        stage_nxt_s[STAGES-1].s_done = stage_nxt_s[STAGES-1].ovf
            ? (stage_in_s[STAGES-1].x_rem[WIDTH-1] ? SAT_NEG : SAT_POS)
            : stage_nxt_s[STAGES-1].s_done;
`endif
    end

    // Advance all stages together; hold everything while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                pipe_r[k] <= '{valid: 1'b0, carry: 1'b0, ovf: 1'b0,
                               x_rem: {WIDTH{1'b0}}, y_rem: {WIDTH{1'b0}},
                               s_done: {WIDTH{1'b0}}};
            end
        end else if (!stall_s) begin
            for (int k = 0; k < STAGES; k++) begin
                pipe_r[k] <= stage_nxt_s[k];
            end
        end
    end

    // Outputs come straight from the last stage register.
    assign out_valid = pipe_r[STAGES-1].valid;
    assign s         = pipe_r[STAGES-1].s_done;
    assign cout      = pipe_r[STAGES-1].carry;
    assign ovf       = pipe_r[STAGES-1].ovf;

endmodule

// File: tb/tb_rca_pipe_addsub.sv
// Directed bench for rca_pipe_addsub (WIDTH=16, STAGES=4). Expected values
// are hand-computed for the directed vectors; streaming phases use a small
// reference model of x +/- y +/- cin and an in-order expectation queue.

module tb_rca_pipe_addsub;

    localparam int WIDTH  = 16;
    localparam int STAGES = 4;

    logic              clk       = 1'b0;
    logic              rst_n     = 1'b0;
    logic              in_valid  = 1'b0;
    logic              in_ready;
    logic [WIDTH-1:0]  x         = 16'h0000;
    logic [WIDTH-1:0]  y         = 16'h0000;
    logic              cin       = 1'b0;
    logic              sub       = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [WIDTH-1:0]  s;
    logic              cout;
    logic              ovf;

    int                n_checks  = 0;
    int                n_fail    = 0;
    int                pushes    = 0;
    int                pops      = 0;
    int                cyc       = 0;
    int                first_pop = -1;
    int                last_pop  = -1;
    logic [17:0]       exp_q [$];

    rca_pipe_addsub #(
        .WIDTH     (WIDTH),
        .STAGES    (STAGES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: {ovf, cout, s}
    function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic ci, input logic sb);
        logic [15:0] yy;
        logic [16:0] sum;
        logic        ov;
        logic [15:0] r;
        yy  = sb ? ~b : b;
        sum = {1'b0, a} + {1'b0, yy} + {16'h0000, ci ^ sb};
        ov  = (a[15] == yy[15]) && (sum[15] != a[15]);
        r   = sum[15:0];
`ifdef ADDSUB_SAT_EN
        if (ov) r = a[15] ? 16'h8000 : 16'h7FFF;
`endif
        return {ov, sum[16], r};
    endfunction

    // One clock of streaming: drive at negedge, then account for the
    // handshakes that the coming rising edge will perform.
    task automatic cycle(input logic v, input logic [15:0] xv, input logic [15:0] yv,
                         input logic ci, input logic sb, input logic ordy);
        logic [17:0] e;
        @(negedge clk);
        in_valid  = v;
        x         = xv;
        y         = yv;
        cin       = ci;
        sub       = sb;
        out_ready = ordy;
        cyc++;
        #1;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", out_valid, 0);
            end else begin
                e = exp_q.pop_front();
                chk("stream_s", s, e[15:0]);
                chk("stream_cout", cout, e[16]);
                chk("stream_ovf", ovf, e[17]);
                pops++;
                if (first_pop < 0) first_pop = cyc;
                last_pop = cyc;
            end
        end
        if (in_valid && in_ready) begin
            exp_q.push_back(model(xv, yv, ci, sb));
            pushes++;
        end
    endtask

    // Single beat into an empty pipe; checks latency and the result.
    task automatic directed(input string tag, input logic [15:0] xv, input logic [15:0] yv,
                            input logic ci, input logic sb, input logic [15:0] es,
                            input logic ec, input logic eo);
        int lat;
        @(negedge clk);
        in_valid  = 1'b1;
        x         = xv;
        y         = yv;
        cin       = ci;
        sub       = sb;
        out_ready = 1'b1;
        #1;
        chk({tag, "_in_ready"}, in_ready, 1);
        lat = 0;
        do begin
            @(negedge clk);
            in_valid = 1'b0;
            lat++;
            #1;
        end while (!out_valid && lat < 10);
        chk({tag, "_latency"}, lat, STAGES);
        chk({tag, "_s"}, s, es);
        chk({tag, "_cout"}, cout, ec);
        chk({tag, "_ovf"}, ovf, eo);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_s", s, 16'h0000);
        chk("rst_cout", cout, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;

        // Directed arithmetic
        directed("add_wrap",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        directed("sub_neg",    16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        directed("sub_borrow", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFD, 1'b0, 1'b0);
        directed("sub_pos",    16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0);
        directed("add_cin",    16'h1234, 16'h1111, 1'b1, 1'b0, 16'h2346, 1'b0, 1'b0);
        directed("chunk_carry",16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
`ifdef ADDSUB_SAT_EN
        directed("ovf_pos",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h7FFF, 1'b0, 1'b1);
        directed("ovf_sub",    16'h8000, 16'h0001, 1'b0, 1'b1, 16'h8000, 1'b1, 1'b1);
        directed("ovf_neg",    16'h8000, 16'h8000, 1'b0, 1'b0, 16'h8000, 1'b1, 1'b1);
`else
        directed("ovf_pos",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        directed("ovf_sub",    16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        directed("ovf_neg",    16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
`endif

        // Back-to-back random beats, downstream always ready
        cyc = 0; pushes = 0; pops = 0; first_pop = -1; last_pop = -1;
        for (int i = 0; i < 100; i++) begin
            cycle(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b1);
        end
        for (int i = 0; i < STAGES + 2; i++) begin
            cycle(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
        end
        chk("t4_pushes", pushes, 100);
        chk("t4_pops", pops, 100);
        chk("t4_span", last_pop - first_pop, 99);
        chk("t4_queue_empty", exp_q.size(), 0);

        // Fill with downstream blocked, hold the stall, then drain
        pushes = 0; pops = 0;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b0);
        end
        chk("t5_accepted", pushes, STAGES);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b0);
            chk("t5_in_ready", in_ready, 0);
            chk("t5_out_valid", out_valid, 1);
            chk("t5_hold_s", s, exp_q[0][15:0]);
            chk("t5_hold_cout", cout, exp_q[0][16]);
            chk("t5_hold_ovf", ovf, exp_q[0][17]);
        end
        chk("t5_no_accept", pushes, STAGES);
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
        end
        chk("t5_pops", pops, STAGES);
        chk("t5_queue_empty", exp_q.size(), 0);
        chk("t5_idle", out_valid, 0);

        // Reset with beats in flight
        pushes = 0; pops = 0;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b0);
        end
        chk("t6_filled", pushes, 4);
        @(negedge clk);
        #2;
        chk("t6_pre_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", out_valid, 0);
        chk("t6_rst_s", s, 16'h0000);
        chk("t6_rst_cout", cout, 0);
        chk("t6_rst_ovf", ovf, 0);
        exp_q.delete();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
            chk("t6_quiet", out_valid, 0);
        end
        chk("t6_none_after", pops, 0);
        directed("t6_after", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
